// File: rtl/arith_issue_ctrl.sv
// arith_issue_ctrl: valid/ready multicycle issue front-end for a combinational add/sub/mul/div datapath
// Optional stat counters are compiled in with ARITH_ISSUE_STATS_EN.
module arith_issue_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  op_a,
    output logic [7:0]  op_b,
    input  logic [7:0]  dp_sum,
    input  logic [7:0]  dp_diff,
    input  logic [15:0] dp_prod,
    input  logic [7:0]  dp_quotient,
    input  logic [7:0]  dp_remainder,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_err
`ifdef ARITH_ISSUE_STATS_EN
    ,
    output logic [15:0] stat_cmd_count,
    output logic [7:0]  stat_err_count
`endif
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic        cmd_hs, dz;
    logic [15:0] res;
    assign cmd_ready = rst_n && (state == IDLE || (state == HOLD && rsp_ready));
    assign cmd_hs = cmd_valid && cmd_ready;
    assign dz = op == 2'd3 && op_b == 8'd0;
    always_comb res = op == 2'd0 ? {8'h00, dp_sum} :
                      op == 2'd1 ? {8'h00, dp_diff} :
                      op == 2'd2 ? dp_prod :
                      dz ? {op_a, 8'hFF} : {dp_remainder, dp_quotient};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_op    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                op_a <= cmd_a;
                op_b <= cmd_b;
                op   <= cmd_op;
                cnt  <= 4'(SETTLE_CYCLES - 1);
            end
            case (state)
                IDLE: if (cmd_valid) state <= SETTLE;
                SETTLE: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= res;
                        rsp_op    <= op;
                        rsp_err   <= dz;
                        rsp_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    // a command arriving with the retiring response skips IDLE
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= cmd_valid ? SETTLE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ARITH_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cmd_count <= '0;
            stat_err_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_cmd_count != '1) stat_cmd_count <= stat_cmd_count + 16'd1;
            if (rsp_err && stat_err_count != '1) stat_err_count <= stat_err_count + 8'd1;
        end
    end
`endif
endmodule
